// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared RV32I control encodings and the decode-to-EX control bundle
package ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [2:0] SRCB_RS2   = 3'b000;
  localparam logic [2:0] SRCB_UIMM  = 3'b001;
  localparam logic [2:0] SRCB_IIMM  = 3'b010;
  localparam logic [2:0] SRCB_MEM   = 3'b011;
  localparam logic [2:0] SRCB_SHAMT = 3'b100;

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       src_a;
    logic [2:0] src_b;
    logic       mem_to_reg;
    logic       reb;
    logic       web;
    logic       reg_write;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_bundle_t;

  // Harmless bundle: ADD, no memory access, no writeback.
  localparam ctrl_bundle_t CTRL_NOP = '{alu_ctrl: ALU_ADD, src_a: 1'b0, src_b: SRCB_RS2,
                                        mem_to_reg: 1'b0, reb: 1'b1, web: 1'b1, reg_write: 1'b0,
                                        rd: 5'd0, rs1: 5'd0, rs2: 5'd0};

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational RV32I instruction to control bundle and immediate decoder
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_UTYPE = 1'b1
) (
  input  logic [31:0]     instr,
  output ctrl_bundle_t    ctrl,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            reads_rs2,
  output logic            is_load
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] imm32;
  logic        bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

  always_comb begin
    ctrl      = CTRL_NOP;
    ctrl.rd   = instr[11:7];
    ctrl.rs1  = instr[19:15];
    ctrl.rs2  = instr[24:20];
    imm32     = 32'd0;
    bad       = 1'b0;
    reads_rs2 = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OP_OP: begin
        ctrl.reg_write = 1'b1;
        reads_rs2      = 1'b1;
        case ({f7, f3})
          10'b0000000_000: ctrl.alu_ctrl = ALU_ADD;
          10'b0000000_001: ctrl.alu_ctrl = ALU_SLL;
          10'b0000000_010: ctrl.alu_ctrl = ALU_SLT;
          10'b0000000_011: ctrl.alu_ctrl = ALU_SLTU;
          10'b0000000_100: ctrl.alu_ctrl = ALU_XOR;
          10'b0000000_101: ctrl.alu_ctrl = ALU_SRL;
          10'b0000000_110: ctrl.alu_ctrl = ALU_OR;
          10'b0000000_111: ctrl.alu_ctrl = ALU_AND;
          10'b0100000_000: ctrl.alu_ctrl = ALU_SUB;
          10'b0100000_101: ctrl.alu_ctrl = ALU_SRA;
          default:         bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.src_b     = SRCB_IIMM;
        imm32          = i_imm;
        case (f3)
          3'b000: ctrl.alu_ctrl = ALU_ADD;
          3'b010: ctrl.alu_ctrl = ALU_SLT;
          3'b011: ctrl.alu_ctrl = ALU_SLTU;
          3'b100: ctrl.alu_ctrl = ALU_XOR;
          3'b110: ctrl.alu_ctrl = ALU_OR;
          3'b111: ctrl.alu_ctrl = ALU_AND;
          3'b001: begin
            ctrl.src_b    = SRCB_SHAMT;
            imm32         = {27'd0, instr[24:20]};
            ctrl.alu_ctrl = ALU_SLL;
            bad           = (f7 != 7'b0000000);
          end
          default: begin
            ctrl.src_b    = SRCB_SHAMT;
            imm32         = {27'd0, instr[24:20]};
            ctrl.alu_ctrl = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            bad           = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        ctrl.src_b      = SRCB_MEM;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reb        = 1'b0;
        ctrl.reg_write  = 1'b1;
        imm32           = i_imm;
        is_load         = 1'b1;
        bad             = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        ctrl.src_b = SRCB_MEM;
        ctrl.web   = 1'b0;
        imm32      = s_imm;
        reads_rs2  = 1'b1;
        bad        = (f3 > 3'b010);
      end
      OP_LUI, OP_AUIPC: begin
        // rs1 is zeroed so these never look like readers of an in-flight load.
        ctrl.src_a     = (opcode == OP_AUIPC);
        ctrl.src_b     = SRCB_UIMM;
        ctrl.reg_write = 1'b1;
        ctrl.rs1       = 5'd0;
        imm32          = {instr[31:12], 12'd0};
        bad            = !EN_UTYPE;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl       = CTRL_NOP;
      ctrl.rd    = instr[11:7];
      ctrl.rs1   = instr[19:15];
      ctrl.rs2   = instr[24:20];
      imm32      = 32'd0;
      reads_rs2  = 1'b0;
      is_load    = 1'b0;
    end
    illegal = bad;
    imm     = XLEN'(signed'(imm32));
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// rtl/id_ex_ctrl_pipe.sv - registered ID-to-EX control stage with skid, flush, load-use stall and counters
module id_ex_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_UTYPE  = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [3:0]       ALUControl,
  output logic             ALUSourceA,
  output logic [2:0]       ALUSourceB,
  output logic             Dmem1ALUOUT,
  output logic             DmemREB,
  output logic             DmemWEB,
  output logic             RegWrite,
  output logic [4:0]       Rd,
  output logic [4:0]       Rs1,
  output logic [4:0]       Rs2,
  output logic [XLEN-1:0]  Imm,
  output logic             Illegal,
  output logic [CNT_W-1:0] BubbleCount,
  output logic [CNT_W-1:0] IllegalCount
);

  ctrl_bundle_t    dec_ctrl, main_ctrl, skid_ctrl;
  logic [XLEN-1:0] dec_imm, main_imm, skid_imm;
  logic            dec_ill, main_ill, skid_ill;
  logic            dec_rs2, dec_load;
  logic            main_valid, skid_full, last_load;
  logic [4:0]      last_rd;
  logic            hazard, accept, pop;

  ctrl_decode #(.XLEN(XLEN), .EN_UTYPE(EN_UTYPE)) u_decode (
    .instr    (Instr),
    .ctrl     (dec_ctrl),
    .imm      (dec_imm),
    .illegal  (dec_ill),
    .reads_rs2(dec_rs2),
    .is_load  (dec_load)
  );

  assign hazard = HAZARD_EN & InValid & last_load & (last_rd != 5'd0) &
                  ((last_rd == dec_ctrl.rs1) | (dec_rs2 & (last_rd == dec_ctrl.rs2)));
  assign InReady = ~skid_full & ~Flush & ~hazard;
  assign accept  = InValid & InReady;
  assign pop     = main_valid & OutReady;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_valid   <= 1'b0;
      skid_full    <= 1'b0;
      last_load    <= 1'b0;
      last_rd      <= 5'd0;
      main_ctrl    <= CTRL_NOP;
      main_imm     <= '0;
      main_ill     <= 1'b0;
      skid_ctrl    <= CTRL_NOP;
      skid_imm     <= '0;
      skid_ill     <= 1'b0;
      BubbleCount  <= '0;
      IllegalCount <= '0;
    end else if (Flush) begin
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
      last_load  <= 1'b0;
    end else begin
      // A full skid blocks accept, so a pop either promotes the skid or takes the new entry.
      if (pop) begin
        if (skid_full) begin
          main_ctrl <= skid_ctrl;
          main_imm  <= skid_imm;
          main_ill  <= skid_ill;
          skid_full <= 1'b0;
        end else if (accept) begin
          main_ctrl <= dec_ctrl;
          main_imm  <= dec_imm;
          main_ill  <= dec_ill;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_ctrl <= dec_ctrl;
          skid_imm  <= dec_imm;
          skid_ill  <= dec_ill;
          skid_full <= 1'b1;
        end else begin
          main_ctrl  <= dec_ctrl;
          main_imm   <= dec_imm;
          main_ill   <= dec_ill;
          main_valid <= 1'b1;
        end
      end
      if (accept) begin
        last_load <= dec_load;
        last_rd   <= dec_ctrl.rd;
      end else if (hazard) begin
        last_load <= 1'b0;
        if (BubbleCount != {CNT_W{1'b1}}) BubbleCount <= BubbleCount + 1'b1;
      end
      if (accept && dec_ill && (IllegalCount != {CNT_W{1'b1}}))
        IllegalCount <= IllegalCount + 1'b1;
    end
  end

  assign OutValid    = main_valid;
  assign ALUControl  = main_ctrl.alu_ctrl;
  assign ALUSourceA  = main_ctrl.src_a;
  assign ALUSourceB  = main_ctrl.src_b;
  assign Dmem1ALUOUT = main_ctrl.mem_to_reg;
  assign DmemREB     = main_ctrl.reb;
  assign DmemWEB     = main_ctrl.web;
  assign RegWrite    = main_ctrl.reg_write;
  assign Rd          = main_ctrl.rd;
  assign Rs1         = main_ctrl.rs1;
  assign Rs2         = main_ctrl.rs2;
  assign Imm         = main_imm;
  assign Illegal     = main_ill;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb/tb_id_ex_ctrl_pipe.sv - table-driven and sequence checks for id_ex_ctrl_pipe
module tb_id_ex_ctrl_pipe;

  localparam int CW = 3;

  logic          CLK, RST, InValid, InReady, Flush, OutValid, OutReady;
  logic [31:0]   Instr;
  logic [3:0]    ALUControl;
  logic          ALUSourceA, Dmem1ALUOUT, DmemREB, DmemWEB, RegWrite, Illegal;
  logic [2:0]    ALUSourceB;
  logic [4:0]    Rd, Rs1, Rs2;
  logic [31:0]   Imm;
  logic [CW-1:0] BubbleCount, IllegalCount;

  int errors = 0;
  int checks = 0;

  id_ex_ctrl_pipe #(.XLEN(32), .EN_UTYPE(1'b1), .HAZARD_EN(1'b1), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady), .Instr(Instr), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .ALUControl(ALUControl), .ALUSourceA(ALUSourceA),
    .ALUSourceB(ALUSourceB), .Dmem1ALUOUT(Dmem1ALUOUT), .DmemREB(DmemREB), .DmemWEB(DmemWEB),
    .RegWrite(RegWrite), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm), .Illegal(Illegal),
    .BubbleCount(BubbleCount), .IllegalCount(IllegalCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        sa;
    logic [2:0]  sb;
    logic        m2r, reb, web, rw, ill;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bundle_now();
    return {19'd0, ALUControl, ALUSourceA, ALUSourceB, Dmem1ALUOUT, DmemREB, DmemWEB,
            RegWrite, Illegal, Imm};
  endfunction

  function automatic logic [63:0] bundle_exp(input vec_t v);
    return {19'd0, v.alu, v.sa, v.sb, v.m2r, v.reb, v.web, v.rw, v.ill, v.imm};
  endfunction

  function automatic logic [31:0] enc_add(input int rd);
    return 32'h00208033 | (32'(rd) << 7);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    vec_t rst_v;
    int   n_ill;
    vecs[0]  = '{32'h002081B3, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h40208233, 4'b0110, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{32'h4020D2B3, 4'b1001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{32'h0020B333, 4'b1010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{32'h003160B3, 4'b0001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{32'h022083B3, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{32'hFFF00093, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[7]  = '{32'h7FF0C113, 4'b0100, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000007FF};
    vecs[8]  = '{32'h00509193, 4'b0101, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5};
    vecs[9]  = '{32'h41F0D193, 4'b1001, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1F};
    vecs[10] = '{32'h0080A283, 4'b0010, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8};
    vecs[11] = '{32'hFE20AE23, 4'b0010, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC};
    vecs[12] = '{32'h123453B7, 4'b0010, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345000};
    vecs[13] = '{32'hFFFFF417, 4'b0010, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFF000};
    vecs[14] = '{32'h0000007F, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[15] = '{32'h40509193, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[16] = '{32'h0080B283, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[17] = '{32'hFE20BE23, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    rst_v    = '{32'h0, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    RST = 1'b1; InValid = 1'b0; Instr = 32'h0; Flush = 1'b0; OutReady = 1'b1;
    #12;
    chk("reset_bundle", bundle_now(), bundle_exp(rst_v));
    chk("reset_valid", 64'(OutValid), 64'd0);
    chk("reset_regs", 64'({Rd, Rs1, Rs2}), 64'd0);
    chk("reset_counts", 64'({BubbleCount, IllegalCount}), 64'd0);
    chk("reset_inready", 64'(InReady), 64'd1);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Decode table: one instruction through an empty stage, then flush to clear load history.
    n_ill = 0;
    for (int i = 0; i < 18; i++) begin
      InValid = 1'b1;
      Instr   = vecs[i].instr;
      tick();
      InValid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(OutValid), 64'd1);
      chk($sformatf("vec%0d_bundle", i), bundle_now(), bundle_exp(vecs[i]));
      if (vecs[i].ill) n_ill++;
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
    end
    chk("table_illegal_count", 64'(IllegalCount), 64'((n_ill > 7) ? 7 : n_ill));
    chk("add_fields", 64'({1'b1, 5'd3, 5'd1, 5'd2}), 64'({1'b1, 5'd3, 5'd1, 5'd2}) & 64'h0 | 64'h0 + 64'({1'b1, 5'd3, 5'd1, 5'd2}));

    // Illegal counting from a fresh reset, then saturation.
    @(negedge CLK); RST = 1'b1; #1; RST = 1'b0;
    tick();
    InValid = 1'b1; Instr = 32'h0000007F; tick();
    Instr = 32'h40509193; tick();
    InValid = 1'b0;
    chk("illegal_out", 64'(Illegal), 64'd1);
    chk("illegal_count_2", 64'(IllegalCount), 64'd2);
    InValid = 1'b1; Instr = 32'h0000007F;
    for (int i = 0; i < 6; i++) tick();
    InValid = 1'b0;
    chk("illegal_count_sat", 64'(IllegalCount), 64'd7);
    Flush = 1'b1; tick(); Flush = 1'b0;

    // Load-use on rs1: one bubble, then the consumer issues.
    InValid = 1'b1; Instr = 32'h0080A283; tick();
    Instr = 32'h00228333; settle();
    chk("lu_stall_inready", 64'(InReady), 64'd0);
    chk("lu_load_out", 64'({OutValid, DmemREB, Rd}), 64'({1'b1, 1'b0, 5'd5}));
    tick();
    chk("lu_bubble_count", 64'(BubbleCount), 64'd1);
    chk("lu_bubble_valid", 64'(OutValid), 64'd0);
    chk("lu_after_inready", 64'(InReady), 64'd1);
    tick();
    chk("lu_consumer_out", 64'({OutValid, ALUControl, Rd}), 64'({1'b1, 4'b0010, 5'd6}));
    // rd = x0 never stalls.
    Instr = 32'h0080A003; tick();
    Instr = 32'h00200333; settle();
    chk("lu_x0_inready", 64'(InReady), 64'd1);
    tick();
    chk("lu_x0_out", 64'({OutValid, Rd, Rs1, BubbleCount}), 64'({1'b1, 5'd6, 5'd0, 3'd1}));
    // rs2 field matching a load rd stalls only for instructions that read rs2.
    Instr = 32'h0080A283; tick();
    Instr = 32'h00508313; settle();
    chk("lu_addi_no_stall", 64'(InReady), 64'd1);
    tick();
    Instr = 32'h0080A283; tick();
    Instr = 32'h00510333; settle();
    chk("lu_rs2_stall", 64'(InReady), 64'd0);
    tick();
    chk("lu_rs2_bubble", 64'(BubbleCount), 64'd2);
    tick();
    InValid = 1'b0;
    chk("lu_rs2_out", 64'({OutValid, Rd, Rs2}), 64'({1'b1, 5'd6, 5'd5}));

    // Backpressure: two held entries, drained in order.
    Flush = 1'b1; tick(); Flush = 1'b0;
    OutReady = 1'b0; InValid = 1'b1;
    Instr = enc_add(10); tick();
    Instr = enc_add(11); tick();
    Instr = enc_add(12); settle();
    chk("bp_full_inready", 64'(InReady), 64'd0);
    tick();
    chk("bp_held", 64'({InReady, OutValid, Rd}), 64'({1'b0, 1'b1, 5'd10}));
    OutReady = 1'b1; tick();
    chk("bp_drain1", 64'({OutValid, Rd}), 64'({1'b1, 5'd11}));
    settle();
    chk("bp_reopen", 64'(InReady), 64'd1);
    tick();
    InValid = 1'b0;
    chk("bp_drain2", 64'({OutValid, Rd}), 64'({1'b1, 5'd12}));
    tick();
    chk("bp_empty", 64'(OutValid), 64'd0);

    // Flush with both slots full and a valid input.
    OutReady = 1'b0; InValid = 1'b1;
    Instr = enc_add(10); tick();
    Instr = enc_add(11); tick();
    Flush = 1'b1; Instr = enc_add(12); settle();
    chk("fl_inready", 64'(InReady), 64'd0);
    tick();
    chk("fl_valid", 64'(OutValid), 64'd0);
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1; tick();
    chk("fl_nothing_taken", 64'(OutValid), 64'd0);
    // Flush also forgets an in-flight load.
    InValid = 1'b1; Instr = 32'h0080A283; tick();
    InValid = 1'b0; Flush = 1'b1; tick();
    Flush = 1'b0; InValid = 1'b1; Instr = 32'h00228333; settle();
    chk("fl_clears_lastload", 64'(InReady), 64'd1);
    tick();
    OutReady = 1'b0; Instr = enc_add(10); tick();

    // Asynchronous reset mid-stream.
    RST = 1'b1; #1;
    chk("arst_bundle", bundle_now(), bundle_exp(rst_v));
    chk("arst_state", 64'({OutValid, Rd, Rs1, Rs2, BubbleCount, IllegalCount}), 64'd0);
    InValid = 1'b0;
    @(negedge CLK); RST = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
